// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, handles decode's stall/redirect requests and the halt handshake.
module fetch_stage #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE   = 4'hF,
    parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        BranchTaken,
    input  logic [15:0] BranchAddr,
    input  logic        HLT,
    output logic [15:0] instruction,
    output logic [15:0] PC_plus_2,
    output logic        flush_out,
    output logic        stall_out,
    output logic        halted,
    output logic [15:0] pc
);

    typedef enum logic [1:0] {StRun, StHaltPend, StHalted} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus_2_q, pc_plus_2_d;
    logic        flush_q, flush_d;
    logic        stall_q, stall_d;
    logic        halted_q, halted_d;

    logic [15:0] pc_inc;
    logic        is_hlt_word;
    logic        halt_now;

    assign pc_inc      = pc_q + 16'd2;
    assign is_hlt_word = (imem_data[15:12] == HLT_OPCODE);
    // Decode only owns a live halt when the IF/ID entry it is decoding is not a bubble.
    assign halt_now    = HLT && !flush_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a stall freezes the FSM in every live state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (!stall_in) begin
                    if (BranchTaken) begin
                        state_d = StRun;
                    end else if (halt_now) begin
                        state_d = StHalted;
                    end else if (!flush_in && is_hlt_word) begin
                        state_d = StHaltPend;
                    end
                end
            end
            StHaltPend: begin
                if (!stall_in) begin
                    if (BranchTaken) begin
                        state_d = StRun;
                    end else if (halt_now) begin
                        state_d = StHalted;
                    end
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    // Next values of PC, IF/ID register and status flags
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus_2_d = pc_plus_2_q;
        flush_d     = flush_q;
        stall_d     = 1'b0;
        halted_d    = halted_q;
        if (state_q == StHalted) begin
            instr_d     = BUBBLE_INSTR;
            pc_plus_2_d = 16'h0000;
            flush_d     = 1'b1;
        end else if (stall_in) begin
            // Stall wins over redirect: a stalled branch may have read stale operands.
            stall_d = 1'b1;
        end else if (BranchTaken) begin
            pc_d        = BranchAddr;
            instr_d     = BUBBLE_INSTR;
            pc_plus_2_d = 16'h0000;
            flush_d     = 1'b1;
        end else if (halt_now || flush_in || (state_q == StHaltPend)) begin
            // Squash without redirect; a pending halt never refetches.
            instr_d     = BUBBLE_INSTR;
            pc_plus_2_d = 16'h0000;
            flush_d     = 1'b1;
            if (halt_now) begin
                halted_d = 1'b1;
            end
        end else begin
            instr_d     = imem_data;
            pc_plus_2_d = pc_inc;
            flush_d     = 1'b0;
            // A predecoded halt parks the PC on its own address.
            if (!is_hlt_word) begin
                pc_d = pc_inc;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            instr_q     <= BUBBLE_INSTR;
            pc_plus_2_q <= 16'h0000;
            flush_q     <= 1'b1;
            stall_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_plus_2_q <= pc_plus_2_d;
            flush_q     <= flush_d;
            stall_q     <= stall_d;
            halted_q    <= halted_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        imem_addr   = pc_q;
        pc          = pc_q;
        instruction = instr_q;
        PC_plus_2   = pc_plus_2_q;
        flush_out   = flush_q;
        stall_out   = stall_q;
        halted      = halted_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall_in, flush_in, BranchTaken, HLT;
    logic [15:0] BranchAddr;
    logic [15:0] instruction, PC_plus_2, pc;
    logic        flush_out, stall_out, halted;

    logic [15:0] mem [0:32767];
    assign imem_data = mem[imem_addr[15:1]];

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 fetching, 1 halt pending, 2 halted
    logic [15:0] m_pc, m_instr, m_pp2;
    logic        m_flush, m_stall, m_halted;
    int          m_mode;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall_in    (stall_in),
        .flush_in    (flush_in),
        .BranchTaken (BranchTaken),
        .BranchAddr  (BranchAddr),
        .HLT         (HLT),
        .instruction (instruction),
        .PC_plus_2   (PC_plus_2),
        .flush_out   (flush_out),
        .stall_out   (stall_out),
        .halted      (halted),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
        m_flush = 1'b1; m_stall = 1'b0; m_halted = 1'b0; m_mode = 0;
    endtask

    task automatic model_bubble();
        m_instr = 16'h0000; m_pp2 = 16'h0000; m_flush = 1'b1;
    endtask

    task automatic clear_inputs();
        stall_in = 0; flush_in = 0; BranchTaken = 0; HLT = 0; BranchAddr = 16'h0000;
    endtask

    // Advance the model with the current inputs, then clock the DUT and settle.
    task automatic tick();
        logic [15:0] word;
        word = mem[m_pc[15:1]];
        if (m_mode == 2) begin
            model_bubble();
            m_stall = 1'b0;
        end else if (stall_in) begin
            m_stall = 1'b1;
        end else begin
            m_stall = 1'b0;
            if (BranchTaken) begin
                m_pc = BranchAddr;
                model_bubble();
                m_mode = 0;
            end else if (HLT && !m_flush) begin
                m_halted = 1'b1;
                m_mode = 2;
                model_bubble();
            end else if (m_mode == 1 || flush_in) begin
                model_bubble();
            end else begin
                m_instr = word;
                m_pp2 = m_pc + 16'd2;
                m_flush = 1'b0;
                if (word[15:12] == 4'hF) m_mode = 1;
                else m_pc = m_pc + 16'd2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if (pc !== 16'h0000 || instruction !== 16'h0000 || PC_plus_2 !== 16'h0000 ||
            flush_out !== 1'b1 || stall_out !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h instr=%h pp2=%h flush=%b stall=%b halted=%b exp 0000 0000 0000 1 0 0",
                     pc, instruction, PC_plus_2, flush_out, stall_out, halted);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (pc !== 16'h0000 || flush_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold pc=%h flush=%b exp 0000 1", pc, flush_out);
        end
    endtask

    task automatic test_sequential();
        checks++;
        if (imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL seq_addr0 imem_addr=%h exp 0000", imem_addr);
        end
        tick();
        checks++;
        if (imem_addr !== 16'h0002 || instruction !== 16'h1234 || PC_plus_2 !== 16'h0002 ||
            flush_out !== 1'b0) begin
            errors++;
            $display("FAIL seq_first addr=%h instr=%h pp2=%h flush=%b exp 0002 1234 0002 0",
                     imem_addr, instruction, PC_plus_2, flush_out);
        end
        tick();
        checks++;
        if (imem_addr !== 16'h0004 || instruction !== 16'h2345 || PC_plus_2 !== 16'h0004 ||
            flush_out !== 1'b0) begin
            errors++;
            $display("FAIL seq_second addr=%h instr=%h pp2=%h flush=%b exp 0004 2345 0004 0",
                     imem_addr, instruction, PC_plus_2, flush_out);
        end
    endtask

    task automatic test_stall();
        stall_in = 1'b1;
        tick();
        stall_in = 1'b0;
        checks++;
        if (pc !== 16'h0004 || instruction !== 16'h2345 || PC_plus_2 !== 16'h0004 ||
            stall_out !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold pc=%h instr=%h pp2=%h stall=%b exp 0004 2345 0004 1",
                     pc, instruction, PC_plus_2, stall_out);
        end
        tick();
        checks++;
        if (pc !== 16'h0006 || instruction !== 16'h3456 || PC_plus_2 !== 16'h0006 ||
            stall_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume pc=%h instr=%h pp2=%h stall=%b exp 0006 3456 0006 0",
                     pc, instruction, PC_plus_2, stall_out);
        end
    endtask

    task automatic test_branch();
        BranchTaken = 1'b1; flush_in = 1'b1; BranchAddr = 16'h0040;
        tick();
        clear_inputs();
        checks++;
        if (pc !== 16'h0040 || flush_out !== 1'b1 || instruction !== 16'h0000) begin
            errors++;
            $display("FAIL branch_bubble pc=%h flush=%b instr=%h exp 0040 1 0000",
                     pc, flush_out, instruction);
        end
        tick();
        checks++;
        if (instruction !== 16'h6789 || PC_plus_2 !== 16'h0042 || flush_out !== 1'b0 ||
            pc !== 16'h0042) begin
            errors++;
            $display("FAIL branch_target instr=%h pp2=%h flush=%b pc=%h exp 6789 0042 0 0042",
                     instruction, PC_plus_2, flush_out, pc);
        end
    endtask

    task automatic test_stall_vs_branch();
        stall_in = 1'b1; BranchTaken = 1'b1; flush_in = 1'b1; BranchAddr = 16'h0080;
        tick();
        clear_inputs();
        checks++;
        if (pc !== 16'h0042 || stall_out !== 1'b1 || instruction !== 16'h6789 ||
            flush_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_beats_branch pc=%h stall=%b instr=%h flush=%b exp 0042 1 6789 0",
                     pc, stall_out, instruction, flush_out);
        end
        tick();
        checks++;
        if (pc !== 16'h0044 || instruction !== 16'h789a || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL after_stall_branch pc=%h instr=%h stall=%b exp 0044 789a 0",
                     pc, instruction, stall_out);
        end
    endtask

    task automatic test_halt();
        BranchTaken = 1'b1; flush_in = 1'b1; BranchAddr = 16'h000a;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (pc !== 16'h000a || instruction !== 16'hf000 || flush_out !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_fetch pc=%h instr=%h flush=%b halted=%b exp 000a f000 0 0",
                     pc, instruction, flush_out, halted);
        end
        HLT = 1'b1;
        tick();
        HLT = 1'b0;
        checks++;
        if (halted !== 1'b1 || pc !== 16'h000a || flush_out !== 1'b1) begin
            errors++;
            $display("FAIL halt_enter halted=%b pc=%h flush=%b exp 1 000a 1", halted, pc, flush_out);
        end
        for (int i = 0; i < 22; i++) begin
            stall_in = 1'($urandom_range(0, 1));
            BranchTaken = 1'($urandom_range(0, 1));
            flush_in = 1'($urandom_range(0, 1));
            HLT = 1'($urandom_range(0, 1));
            BranchAddr = 16'($urandom) & 16'hfffe;
            tick();
            checks++;
            if (pc !== 16'h000a || flush_out !== 1'b1 || instruction !== 16'h0000 ||
                halted !== 1'b1 || stall_out !== 1'b0) begin
                errors++;
                $display("FAIL halted_frozen cyc=%0d pc=%h flush=%b instr=%h halted=%b stall=%b exp 000a 1 0000 1 0",
                         i, pc, flush_out, instruction, halted, stall_out);
            end
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== 16'h0000 || halted !== 1'b0 || flush_out !== 1'b1 || stall_out !== 1'b0 ||
            instruction !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset pc=%h halted=%b flush=%b stall=%b instr=%h exp 0000 0 1 0 0000",
                     pc, halted, flush_out, stall_out, instruction);
        end
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_halt_pend_branch();
        BranchTaken = 1'b1; flush_in = 1'b1; BranchAddr = 16'h000a;
        tick();
        clear_inputs();
        tick();
        BranchTaken = 1'b1; flush_in = 1'b1; BranchAddr = 16'h0020;
        tick();
        clear_inputs();
        checks++;
        if (pc !== 16'h0020 || flush_out !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL pend_branch pc=%h flush=%b halted=%b exp 0020 1 0", pc, flush_out, halted);
        end
        tick();
        checks++;
        if (pc !== 16'h0022 || instruction !== mem[16] || PC_plus_2 !== 16'h0022 ||
            flush_out !== 1'b0) begin
            errors++;
            $display("FAIL pend_resume pc=%h instr=%h pp2=%h flush=%b exp 0022 %h 0022 0",
                     pc, instruction, PC_plus_2, flush_out, mem[16]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            mem[$urandom_range(0, 127)] = 16'hf000 | 16'($urandom_range(0, 4095));
        end
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
                model_reset();
            end
            stall_in = ($urandom_range(0, 5) == 0);
            BranchTaken = ($urandom_range(0, 7) == 0);
            flush_in = BranchTaken || ($urandom_range(0, 15) == 0);
            BranchAddr = BranchTaken ? (16'($urandom_range(0, 127)) << 1) : 16'($urandom);
            HLT = (!m_flush && m_instr[15:12] == 4'hF && $urandom_range(0, 1) == 1) ||
                  ($urandom_range(0, 31) == 0);
            tick();
            checks++;
            if (pc !== m_pc || imem_addr !== m_pc || instruction !== m_instr ||
                PC_plus_2 !== m_pp2 || flush_out !== m_flush || stall_out !== m_stall ||
                halted !== m_halted) begin
                errors++;
                $display("FAIL random cyc=%0d pc=%h instr=%h pp2=%h flush=%b stall=%b halted=%b exp %h %h %h %b %b %b",
                         i, pc, instruction, PC_plus_2, flush_out, stall_out, halted,
                         m_pc, m_instr, m_pp2, m_flush, m_stall, m_halted);
            end
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w = w ^ 16'h1000;
            mem[i] = w;
        end
        mem[0]  = 16'h1234;
        mem[1]  = 16'h2345;
        mem[2]  = 16'h3456;
        mem[3]  = 16'h4567;
        mem[5]  = 16'hf000;
        mem[32] = 16'h6789;
        mem[33] = 16'h789a;
        model_reset();

        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_stall_vs_branch();
        test_halt();
        test_async_reset();
        test_halt_pend_branch();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
